rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Parametrised register file with an integrated pending-write scoreboard for the pipelined datapath. It replaces the fixed 32×32, single-write register file. It adds configurable data width and depth, a hardwired zero register, and write-to-read bypass. It also tracks per-register pending bits so the issue stage can detect read-after-write hazards, and it clears everything on an asynchronous reset. It sits between the decode/issue stage (read ports, issue port) and the writeback stage (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending
- BYPASS, 1, when 1, same-cycle writeback data is forwarded to the read ports

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- rs_data  output  DATA_W  read port A data (combinational)
- rt_data  output  DATA_W  read port B data (combinational)
- rs_ready  output  1  port A operand is valid (no outstanding write)
- rt_ready  output  1  port B operand is valid
- iss_en  input  1  issue stage claims a destination register
- iss_addr  input  ADDR_W  destination being claimed
- wb_en  input  1  writeback strobe
- wb_addr  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback value
- flush  input  1  synchronous clear of all pending bits; data is retained
- pend_cnt  output  ADDR_W+1  registered count of pending registers

## Operation
- Storage: 2**ADDR_W × DATA_W registers, plus one pending bit per register.
- Write: on the clk edge with wb_en=1, reg[wb_addr] ← wb_data and pend[wb_addr] ← 0. The write is ignored when ZERO_REG=1 and wb_addr=0.
- Issue: on the clk edge with iss_en=1, pend[iss_addr] ← 1. The issue is ignored when ZERO_REG=1 and iss_addr=0.
- Issue and writeback to the same address in the same cycle: data is written and the pending bit ends at 1 (issue wins).
- Flush: on the clk edge with flush=1, all pending bits go to 0. An iss_en in the same cycle still sets its bit (issue wins over flush). A wb_en in the same cycle still writes data.
- Read, per port, combinational:
  - ZERO_REG=1 and addr=0: data=0, ready=1.
  - Otherwise, if BYPASS=1, wb_en=1 and wb_addr=addr: data=wb_data, ready=1.
  - Otherwise: data=reg[addr], ready=!pend[addr].
- Read ports never see a same-cycle issue; ready reflects pending state as of the last edge.
- pend_cnt: register equal to the popcount of the pending bits after each edge. Range is 0..2**ADDR_W (or 2**ADDR_W−1 with ZERO_REG=1).

## Timing
- Reset (rst_n=0, asynchronous): all registers 0, all pending bits 0, pend_cnt=0. During and immediately after reset, rs_data/rt_data=0 and rs_ready/rt_ready=1 (absent bypass).
- Reset asserted mid-operation overrides any same-cycle iss_en, wb_en or flush.
- Read latency is 0 cycles (combinational).
- A write is visible through storage on the cycle after the wb_en edge. With BYPASS=1 it is also visible in the same cycle.
- Issue-to-not-ready latency is 1 edge.
- pend_cnt is valid one edge after any change.
- Inputs must be stable around the rising clk edge; there is no handshake back-pressure, and the block accepts one issue and one writeback per cycle.

## Test plan
- Reset: drive rst_n=0 mid-run after writing reg 3=0xDEADBEEF and issuing reg 4 → immediately rs_addr=3 reads 0, rt_addr=4 gives rt_ready=1, pend_cnt=0.
- RAW hazard: iss_en to reg 5; next cycle rs_addr=5 → rs_ready=0 and pend_cnt=1. Then wb_en reg 5=0x1234 with BYPASS=1 → same cycle rs_data=0x1234, rs_ready=1; after the edge, pend_cnt=0.
- BYPASS=0 instance: wb reg 7=0xA5A5 with rs_addr=7 → same cycle old value and rs_ready=0 if pending; after the edge, 0xA5A5 and rs_ready=1.
- Zero register: wb reg 0=0xFFFFFFFF and iss reg 0 → rs_data=0, rs_ready=1, pend_cnt unchanged. With ZERO_REG=0, reg 0 behaves like any other register.
- Simultaneous events: iss and wb to reg 9 in one cycle → after the edge, reg 9 holds wb_data and is pending. flush with iss reg 2 while regs 2, 3 and 6 are pending → pend_cnt=1 and only reg 2 is pending.
- Capacity: issue every non-zero register with ADDR_W=3 → pend_cnt=7 (ZERO_REG=1). Writeback of all of them → pend_cnt returns to 0 with no wrap.

Source files
------------

// File: rtl/rf_scoreboard.sv
// Parametrised register file with per-register pending bits for RAW hazard detection.
// Read ports are combinational with optional same-cycle writeback forwarding.
module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_ready,
    output logic              rt_ready,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W:0]   r_pend_cnt;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_wb_ok;
    logic              w_iss_ok;

    assign w_wb_ok  = wb_en  && !(ZERO_REG && (wb_addr  == '0));
    assign w_iss_ok = iss_en && !(ZERO_REG && (iss_addr == '0));

    // Priority: flush < writeback clear < issue set.
    always_comb begin
        w_pend_nxt = flush ? '0 : r_pend;
        if (w_wb_ok)
            w_pend_nxt[wb_addr] = 1'b0;
        if (w_iss_ok)
            w_pend_nxt[iss_addr] = 1'b1;
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_wb_ok)
                r_regs[wb_addr] <= wb_data;
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        rs_data  = r_regs[rs_addr];
        rs_ready = !r_pend[rs_addr];
        if (ZERO_REG && (rs_addr == '0)) begin
            rs_data  = '0;
            rs_ready = 1'b1;
        end else if (BYPASS && wb_en && (wb_addr == rs_addr)) begin
            rs_data  = wb_data;
            rs_ready = 1'b1;
        end
    end

    always_comb begin
        rt_data  = r_regs[rt_addr];
        rt_ready = !r_pend[rt_addr];
        if (ZERO_REG && (rt_addr == '0)) begin
            rt_data  = '0;
            rt_ready = 1'b1;
        end else if (BYPASS && wb_en && (wb_addr == rt_addr)) begin
            rt_data  = wb_data;
            rt_ready = 1'b1;
        end
    end

    assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: a default instance driven from a vector table,
// plus small instances for no-bypass/no-zero-register and full-capacity sequences.
module tb_rf_scoreboard;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    // Instance A: defaults (32x32, zero register, bypass)
    logic [4:0]  a_rs_addr, a_rt_addr, a_iss_addr, a_wb_addr;
    logic [31:0] a_rs_data, a_rt_data, a_wb_data;
    logic        a_rs_ready, a_rt_ready, a_iss_en, a_wb_en, a_flush;
    logic [5:0]  a_pend_cnt;

    // Instance B: 8 regs, no zero register, no bypass
    logic [2:0]  b_rs_addr, b_rt_addr, b_iss_addr, b_wb_addr;
    logic [31:0] b_rs_data, b_rt_data, b_wb_data;
    logic        b_rs_ready, b_rt_ready, b_iss_en, b_wb_en, b_flush;
    logic [3:0]  b_pend_cnt;

    // Instance C: 8 regs, zero register, bypass
    logic [2:0]  c_rs_addr, c_rt_addr, c_iss_addr, c_wb_addr;
    logic [31:0] c_rs_data, c_rt_data, c_wb_data;
    logic        c_rs_ready, c_rt_ready, c_iss_en, c_wb_en, c_flush;
    logic [3:0]  c_pend_cnt;

    rf_scoreboard u_a (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(a_rs_addr), .rt_addr(a_rt_addr),
        .rs_data(a_rs_data), .rt_data(a_rt_data),
        .rs_ready(a_rs_ready), .rt_ready(a_rt_ready),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr),
        .wb_en(a_wb_en), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
        .flush(a_flush), .pend_cnt(a_pend_cnt)
    );

    rf_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
        .rs_data(b_rs_data), .rt_data(b_rt_data),
        .rs_ready(b_rs_ready), .rt_ready(b_rt_ready),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr),
        .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
        .flush(b_flush), .pend_cnt(b_pend_cnt)
    );

    rf_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(c_rs_addr), .rt_addr(c_rt_addr),
        .rs_data(c_rs_data), .rt_data(c_rt_data),
        .rs_ready(c_rs_ready), .rt_ready(c_rt_ready),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr),
        .wb_en(c_wb_en), .wb_addr(c_wb_addr), .wb_data(c_wb_data),
        .flush(c_flush), .pend_cnt(c_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        iss;
        logic [4:0]  ia;
        logic        wb;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic [31:0] e_rsd;
        logic        e_rsr;
        logic [31:0] e_rtd;
        logic        e_rtr;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                input logic iss, input logic [4:0] ia,
                                input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                                input logic fl,
                                input logic [31:0] e_rsd, input logic e_rsr,
                                input logic [31:0] e_rtd, input logic e_rtr,
                                input logic [5:0] e_cnt);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.iss = iss; v.ia = ia;
        v.wb = wb; v.wa = wa; v.wd = wd; v.fl = fl;
        v.e_rsd = e_rsd; v.e_rsr = e_rsr; v.e_rtd = e_rtd; v.e_rtr = e_rtr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one row at the falling edge, check reads mid-cycle, check pend_cnt after the rising edge.
    task automatic apply_a(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("row%0d", idx);
        @(negedge clk);
        rst_n      = !v.rst;
        a_rs_addr  = v.rs;  a_rt_addr  = v.rt;
        a_iss_en   = v.iss; a_iss_addr = v.ia;
        a_wb_en    = v.wb;  a_wb_addr  = v.wa; a_wb_data = v.wd;
        a_flush    = v.fl;
        #1;
        chk({tag, " rs_data"},  a_rs_data,  v.e_rsd);
        chk({tag, " rs_ready"}, {31'd0, a_rs_ready}, {31'd0, v.e_rsr});
        chk({tag, " rt_data"},  a_rt_data,  v.e_rtd);
        chk({tag, " rt_ready"}, {31'd0, a_rt_ready}, {31'd0, v.e_rtr});
        @(posedge clk);
        #1;
        chk({tag, " pend_cnt"}, {26'd0, a_pend_cnt}, {26'd0, v.e_cnt});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        a_rs_addr = '0; a_rt_addr = '0; a_iss_en = 1'b0; a_iss_addr = '0;
        a_wb_en = 1'b0; a_wb_addr = '0; a_wb_data = '0; a_flush = 1'b0;
        b_rs_addr = '0; b_rt_addr = '0; b_iss_en = 1'b0; b_iss_addr = '0;
        b_wb_en = 1'b0; b_wb_addr = '0; b_wb_data = '0; b_flush = 1'b0;
        c_rs_addr = '0; c_rt_addr = '0; c_iss_en = 1'b0; c_iss_addr = '0;
        c_wb_en = 1'b0; c_wb_addr = '0; c_wb_data = '0; c_flush = 1'b0;

        //            rst rs  rt  iss ia  wb wa  wd            fl  rsd           rsr rtd          rtr cnt
        vecs.push_back(mk(0, 3,  4,  0, 0,  0, 0,  32'h0,        0, 32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 3,  4,  1, 4,  1, 3,  32'hDEADBEEF, 0, 32'hDEADBEEF, 1, 32'h0,        1, 1));
        vecs.push_back(mk(0, 3,  4,  0, 0,  0, 0,  32'h0,        0, 32'hDEADBEEF, 1, 32'h0,        0, 1));
        vecs.push_back(mk(1, 3,  4,  1, 4,  1, 9,  32'h77,       1, 32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 3,  9,  0, 0,  0, 0,  32'h0,        0, 32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 5,  5,  1, 5,  0, 0,  32'h0,        0, 32'h0,        1, 32'h0,        1, 1));
        vecs.push_back(mk(0, 5,  5,  0, 0,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 5,  6,  0, 0,  1, 5,  32'h1234,     0, 32'h1234,     1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 5,  5,  0, 0,  0, 0,  32'h0,        0, 32'h1234,     1, 32'h1234,     1, 0));
        vecs.push_back(mk(0, 0,  0,  1, 0,  1, 0,  32'hFFFFFFFF, 0, 32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0,  5,  0, 0,  0, 0,  32'h0,        0, 32'h0,        1, 32'h1234,     1, 0));
        vecs.push_back(mk(0, 9,  5,  1, 9,  1, 9,  32'hCAFE,     0, 32'hCAFE,     1, 32'h1234,     1, 1));
        vecs.push_back(mk(0, 9,  9,  0, 0,  0, 0,  32'h0,        0, 32'hCAFE,     0, 32'hCAFE,     0, 1));
        vecs.push_back(mk(0, 2,  9,  1, 2,  0, 0,  32'h0,        0, 32'h0,        1, 32'hCAFE,     0, 2));
        vecs.push_back(mk(0, 3,  2,  1, 3,  0, 0,  32'h0,        0, 32'h0,        1, 32'h0,        0, 3));
        vecs.push_back(mk(0, 6,  3,  1, 6,  0, 0,  32'h0,        0, 32'h0,        1, 32'h0,        0, 4));
        vecs.push_back(mk(0, 2,  6,  1, 2,  1, 3,  32'h33,       1, 32'h0,        0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 2,  3,  0, 0,  0, 0,  32'h0,        0, 32'h0,        0, 32'h33,       1, 1));
        vecs.push_back(mk(0, 6,  9,  0, 0,  0, 0,  32'h0,        0, 32'h0,        1, 32'hCAFE,     1, 1));
        vecs.push_back(mk(0, 6,  2,  0, 0,  1, 2,  32'h22,       0, 32'h0,        1, 32'h22,       1, 0));
        vecs.push_back(mk(0, 2,  31, 0, 0,  0, 0,  32'h0,        0, 32'h22,       1, 32'h0,        1, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset pend_cnt", {26'd0, a_pend_cnt}, 32'd0);
        chk("reset rt_ready", {31'd0, a_rt_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            apply_a(i, vecs[i]);

        // Instance B: reg 0 is ordinary, and writeback is not forwarded.
        @(negedge clk);
        b_iss_en = 1'b1; b_iss_addr = 3'd0; b_rs_addr = 3'd0;
        #1 chk("b iss0 ready pre-edge", {31'd0, b_rs_ready}, 32'd1);
        @(posedge clk); #1 chk("b iss0 pend_cnt", {28'd0, b_pend_cnt}, 32'd1);
        @(negedge clk);
        b_iss_en = 1'b0;
        #1 chk("b reg0 pending", {31'd0, b_rs_ready}, 32'd0);
        @(negedge clk);
        b_wb_en = 1'b1; b_wb_addr = 3'd0; b_wb_data = 32'h55; b_rt_addr = 3'd7;
        #1;
        chk("b wb0 no bypass data", b_rs_data, 32'h0);
        chk("b wb0 no bypass ready", {31'd0, b_rs_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b reg0 data", b_rs_data, 32'h55);
        chk("b reg0 ready", {31'd0, b_rs_ready}, 32'd1);
        chk("b wb0 pend_cnt", {28'd0, b_pend_cnt}, 32'd0);
        @(negedge clk);
        b_wb_en = 1'b0; b_iss_en = 1'b1; b_iss_addr = 3'd7;
        @(posedge clk); #1 chk("b iss7 pend_cnt", {28'd0, b_pend_cnt}, 32'd1);
        @(negedge clk);
        b_iss_en = 1'b0; b_wb_en = 1'b1; b_wb_addr = 3'd7; b_wb_data = 32'hA5A5;
        #1;
        chk("b wb7 old data", b_rt_data, 32'h0);
        chk("b wb7 old ready", {31'd0, b_rt_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b wb7 new data", b_rt_data, 32'hA5A5);
        chk("b wb7 new ready", {31'd0, b_rt_ready}, 32'd1);
        chk("b wb7 pend_cnt", {28'd0, b_pend_cnt}, 32'd0);
        @(negedge clk);
        b_wb_en = 1'b0;

        // Instance C: fill every non-zero register, then drain.
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            c_iss_en = 1'b1; c_iss_addr = 3'(i);
            @(posedge clk); #1;
            chk($sformatf("c fill %0d pend_cnt", i), {28'd0, c_pend_cnt}, 32'(i));
        end
        @(negedge clk);
        c_iss_addr = 3'd0; c_rs_addr = 3'd0; c_rt_addr = 3'd7;
        @(posedge clk); #1;
        chk("c iss0 pend_cnt", {28'd0, c_pend_cnt}, 32'd7);
        chk("c reg0 ready", {31'd0, c_rs_ready}, 32'd1);
        chk("c reg0 data", c_rs_data, 32'h0);
        chk("c reg7 pending", {31'd0, c_rt_ready}, 32'd0);
        @(negedge clk);
        c_iss_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            c_wb_en = 1'b1; c_wb_addr = 3'(i); c_wb_data = 32'(i * 16);
            @(posedge clk); #1;
            chk($sformatf("c drain %0d pend_cnt", i), {28'd0, c_pend_cnt}, 32'(7 - i));
        end
        @(negedge clk);
        c_wb_en = 1'b0;
        #1;
        chk("c reg7 data", c_rt_data, 32'h70);
        chk("c reg7 ready", {31'd0, c_rt_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
